// File: rtl/muxn_pkg.sv
// ---------------------------------------------------------------------------
// muxn_pkg
// Shared types and constants for the muxn_scan selector.
//   state_e     : selector operating state (manual select / automatic scan)
//   MODE_MANUAL : value of the MODE input that requests manual selection
//   MODE_SCAN   : value of the MODE input that requests channel scanning
// ---------------------------------------------------------------------------
package muxn_pkg;

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_e;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage : muxn_pkg

// File: rtl/muxn_dwell_cnt.sv
// ---------------------------------------------------------------------------
// muxn_dwell_cnt
// Dwell-time counter for the scan mode of muxn_scan. Counts EN cycles
// spent on the current channel and flags the last one of each dwell period.
// Ports:
//   CLK   in  system clock, rising edge
//   RST   in  synchronous active-high reset (count -> 0)
//   i_en  in  1 = advance/clear this cycle, 0 = hold
//   i_clr in  force the count to 0 (manual mode, scan entry)
//   o_tc  out terminal count: count equals DWELL-1
// ---------------------------------------------------------------------------
module muxn_dwell_cnt #(
  parameter int DWELL = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tc
);

  localparam int CW = $clog2(DWELL + 1);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] r_cnt;
  logic          w_tc;

  assign w_tc = (r_cnt == LAST);
  assign o_tc = w_tc;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (i_clr || w_tc) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule : muxn_dwell_cnt

// File: rtl/muxn_scan.sv
// ---------------------------------------------------------------------------
// muxn_scan
// N-channel, W-bit registered selector with manual select and automatic
// dwell-timed channel scan.
// Ports:
//   CLK  in  system clock, rising edge
//   RST  in  synchronous active-high reset, overrides EN
//   DIN  in  packed channel data, channel k at DIN[k*W +: W]
//   MODE in  0 = manual, 1 = scan
//   SEL  in  requested channel in manual mode
//   EN   in  1 = run, 0 = freeze all state (CHG forced low)
//   Y    out registered data of the channel shown on CH
//   CH   out channel currently driving Y
//   CHG  out one-cycle pulse after CH changes
//   ERR  out high while a manual request is out of range (SEL >= N)
// ---------------------------------------------------------------------------
module muxn_scan
  import muxn_pkg::*;
#(
  parameter int W     = 8,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N),
  parameter int DWELL = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [N*W-1:0]    DIN,
  input  logic              MODE,
  input  logic [SELW-1:0]   SEL,
  input  logic              EN,
  output logic [W-1:0]      Y,
  output logic [SELW-1:0]   CH,
  output logic              CHG,
  output logic              ERR
);

  localparam logic [SELW:0]   NLIM = (SELW + 1)'(N);
  localparam logic [SELW-1:0] LAST = SELW'(N - 1);

  state_e          r_state;
  logic [SELW-1:0] r_ch;
  logic [W-1:0]    r_y;
  logic            r_chg;
  logic            r_err;

  logic            w_man;
  logic            w_sel_ok;
  logic            w_tc;
  logic [SELW-1:0] w_ch_n;
  logic            w_err_n;
  logic [W-1:0]    w_y_n;

  // Manual rules apply in MANUAL and also on the cycle SCAN drops MODE, so a
  // mode change back to manual wins over a coincident dwell boundary.
  assign w_man    = (r_state == ST_MANUAL) || (MODE == MODE_MANUAL);
  assign w_sel_ok = ({1'b0, SEL} < NLIM);

  // The counter is held at 0 whenever manual rules apply; this also zeroes it
  // on the MANUAL->SCAN entry cycle so a fresh scan dwells a full period.
  muxn_dwell_cnt #(
    .DWELL (DWELL)
  ) u_dwell (
    .CLK   (CLK),
    .RST   (RST),
    .i_en  (EN),
    .i_clr (w_man),
    .o_tc  (w_tc)
  );

  always_comb begin
    w_ch_n  = r_ch;
    w_err_n = 1'b0;
    if (w_man) begin
      if (w_sel_ok) begin
        w_ch_n = SEL;
      end else begin
        w_err_n = 1'b1;
      end
    end else if (w_tc) begin
      // Explicit wrap keeps non-power-of-two N from ever reaching index N.
      w_ch_n = (r_ch == LAST) ? '0 : r_ch + 1'b1;
    end
  end

  // Slice by the next channel so Y and CH always update together.
  assign w_y_n = DIN[int'(w_ch_n) * W +: W];

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_MANUAL;
      r_ch    <= '0;
      r_y     <= '0;
      r_chg   <= 1'b0;
      r_err   <= 1'b0;
    end else if (EN) begin
      case (r_state)
        ST_MANUAL: if (MODE == MODE_SCAN)   r_state <= ST_SCAN;
        ST_SCAN:   if (MODE == MODE_MANUAL) r_state <= ST_MANUAL;
        default:                            r_state <= ST_MANUAL;
      endcase
      r_ch  <= w_ch_n;
      r_y   <= w_y_n;
      r_chg <= (w_ch_n != r_ch);
      r_err <= w_err_n;
    end else begin
      r_chg <= 1'b0;
    end
  end

  assign Y   = r_y;
  assign CH  = r_ch;
  assign CHG = r_chg;
  assign ERR = r_err;

endmodule : muxn_scan

// File: tb/tb_muxn_scan.sv
// ---------------------------------------------------------------------------
// tb_muxn_scan
// Self-checking bench for muxn_scan. Two instances:
//   u_dut3 : W=8, N=3, DWELL=4  (scan wrap, out-of-range, freeze, collisions)
//   u_dut4 : W=8, N=4, DWELL=1  (manual select, DIN tracking, 1-cycle dwell)
// Expected outputs are queued as stimulus is applied and checked #1 after
// the following rising edge.
// ---------------------------------------------------------------------------
module tb_muxn_scan;

  typedef struct {
    bit          dut;   // 0 = u_dut3, 1 = u_dut4
    string       tag;
    logic [7:0]  y;
    logic [1:0]  ch;
    logic        chg;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst3, en3, mode3;
  logic [1:0]  sel3;
  logic [23:0] din3;
  logic [7:0]  y3;
  logic [1:0]  ch3;
  logic        chg3, err3;

  logic        rst4, en4, mode4;
  logic [1:0]  sel4;
  logic [31:0] din4;
  logic [7:0]  y4;
  logic [1:0]  ch4;
  logic        chg4, err4;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  muxn_scan #(.W(8), .N(3), .DWELL(4)) u_dut3 (
    .CLK (clk), .RST (rst3), .DIN (din3), .MODE (mode3), .SEL (sel3),
    .EN (en3), .Y (y3), .CH (ch3), .CHG (chg3), .ERR (err3)
  );

  muxn_scan #(.W(8), .N(4), .DWELL(1)) u_dut4 (
    .CLK (clk), .RST (rst4), .DIN (din4), .MODE (mode4), .SEL (sel4),
    .EN (en4), .Y (y4), .CH (ch4), .CHG (chg4), .ERR (err4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit dut, input string tag, input logic [7:0] y,
                      input logic [1:0] ch, input logic chg, input logic err);
    exp_t e;
    e.dut = dut; e.tag = tag; e.y = y; e.ch = ch; e.chg = chg; e.err = err;
    sbq.push_back(e);
  endtask

  task automatic exp3(input string tag, input logic [7:0] y, input logic [1:0] ch,
                      input logic chg, input logic err);
    push(1'b0, tag, y, ch, chg, err);
  endtask

  task automatic exp4(input string tag, input logic [7:0] y, input logic [1:0] ch,
                      input logic chg, input logic err);
    push(1'b1, tag, y, ch, chg, err);
  endtask

  // Advance one clock and score every expectation queued for this edge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.dut == 1'b0) begin
        chk({e.tag, ".y"},   32'(y3),   32'(e.y));
        chk({e.tag, ".ch"},  32'(ch3),  32'(e.ch));
        chk({e.tag, ".chg"}, 32'(chg3), 32'(e.chg));
        chk({e.tag, ".err"}, 32'(err3), 32'(e.err));
      end else begin
        chk({e.tag, ".y"},   32'(y4),   32'(e.y));
        chk({e.tag, ".ch"},  32'(ch4),  32'(e.ch));
        chk({e.tag, ".chg"}, 32'(chg4), 32'(e.chg));
        chk({e.tag, ".err"}, 32'(err4), 32'(e.err));
      end
    end
  endtask

  initial begin
    // Reset with arbitrary data on the inputs.
    rst3 = 1'b1; en3 = 1'b1; mode3 = 1'b0; sel3 = 2'd0; din3 = 24'h5AA53C;
    rst4 = 1'b1; en4 = 1'b1; mode4 = 1'b0; sel4 = 2'd0; din4 = 32'hDEADBEEF;
    exp3("rst3_a", 8'h00, 2'd0, 1'b0, 1'b0);
    exp4("rst4_a", 8'h00, 2'd0, 1'b0, 1'b0);
    tick();
    exp3("rst3_b", 8'h00, 2'd0, 1'b0, 1'b0);
    exp4("rst4_b", 8'h00, 2'd0, 1'b0, 1'b0);
    tick();

    // Release: channel 0 appears one cycle later.
    din3 = 24'h332211;
    din4 = 32'hDDCCBBAA;
    rst3 = 1'b0; rst4 = 1'b0;
    exp3("rel3", 8'h11, 2'd0, 1'b0, 1'b0);
    exp4("rel4", 8'hAA, 2'd0, 1'b0, 1'b0);
    tick();

    // Manual select 0 -> 2 on the 4-channel instance.
    sel4 = 2'd2;
    exp4("man_sel", 8'hCC, 2'd2, 1'b1, 1'b0);
    tick();
    exp4("man_hold", 8'hCC, 2'd2, 1'b0, 1'b0);
    tick();
    din4[23:16] = 8'h5C;
    exp4("man_track", 8'h5C, 2'd2, 1'b0, 1'b0);
    tick();
    din4 = 32'hDDCCBBAA;

    // DWELL=1 scan: advances every cycle and wraps 3 -> 0.
    mode4 = 1'b1;
    exp4("d1_entry", 8'hCC, 2'd2, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      int c;
      c = (3 + i) % 4;
      exp4($sformatf("d1_scan%0d", i), din4[c*8 +: 8], 2'(c), 1'b1, 1'b0);
      tick();
    end
    mode4 = 1'b0;
    exp4("d1_back", 8'hCC, 2'd2, 1'b1, 1'b0);
    tick();

    // Out-of-range manual request on the 3-channel instance.
    sel3 = 2'd1;
    exp3("oor_pre", 8'h22, 2'd1, 1'b1, 1'b0);
    tick();
    sel3 = 2'd3;
    exp3("oor_err", 8'h22, 2'd1, 1'b0, 1'b1);
    tick();
    exp3("oor_err2", 8'h22, 2'd1, 1'b0, 1'b1);
    tick();
    sel3 = 2'd0;
    exp3("oor_clr", 8'h11, 2'd0, 1'b1, 1'b0);
    tick();

    // Scan wrap: N=3, DWELL=4, changes 4, 8, 12 edges after entry.
    mode3 = 1'b1;
    exp3("scan_entry", 8'h11, 2'd0, 1'b0, 1'b0);
    tick();
    for (int k = 1; k <= 14; k++) begin
      int c;
      c = (k / 4) % 3;
      exp3($sformatf("scan%0d", k), din3[c*8 +: 8], 2'(c), (k % 4) == 0, 1'b0);
      tick();
    end

    // Freeze mid-dwell; Y must not follow DIN while frozen.
    en3 = 1'b0;
    din3[7:0] = 8'h99;
    for (int f = 0; f < 10; f++) begin
      exp3($sformatf("frz%0d", f), 8'h11, 2'd0, 1'b0, 1'b0);
      tick();
    end
    din3 = 24'h332211;
    en3 = 1'b1;
    for (int k = 15; k <= 19; k++) begin
      int c;
      c = (k / 4) % 3;
      exp3($sformatf("resume%0d", k), din3[c*8 +: 8], 2'(c), (k % 4) == 0, 1'b0);
      tick();
    end

    // MODE 1->0 on the dwell boundary with CH=1, SEL=0: manual wins.
    mode3 = 1'b0;
    sel3 = 2'd0;
    exp3("simul", 8'h11, 2'd0, 1'b1, 1'b0);
    tick();
    exp3("simul_hold", 8'h11, 2'd0, 1'b0, 1'b0);
    tick();

    // Reset mid-scan, with EN low to show reset overrides freeze.
    mode3 = 1'b1;
    exp3("rs_entry", 8'h11, 2'd0, 1'b0, 1'b0);
    tick();
    for (int k = 1; k <= 5; k++) begin
      int c;
      c = (k / 4) % 3;
      exp3($sformatf("rs_scan%0d", k), din3[c*8 +: 8], 2'(c), (k % 4) == 0, 1'b0);
      tick();
    end
    rst3 = 1'b1;
    en3 = 1'b0;
    exp3("rst_scan", 8'h00, 2'd0, 1'b0, 1'b0);
    tick();
    rst3 = 1'b0;
    en3 = 1'b1;
    exp3("post_rst", 8'h11, 2'd0, 1'b0, 1'b0);
    tick();
    exp3("post_rst2", 8'h11, 2'd0, 1'b0, 1'b0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_muxn_scan

// File: doc/muxn_scan.md
# muxn_scan

Parametrised N-channel, W-bit registered selector with a manual-select mode and an automatic channel-scan mode. It generalises the 4-input, 1-bit combinational multiplexer: it adds width and channel-count parameters, a registered output, a dwell-timed scan counter, and status flags. It sits between the data sources and the display/output stage of the lab designs.

## Interface
- W, default 8: data width per channel.
- N, default 4: channel count, 2..16, not necessarily a power of two.
- SELW, default $clog2(N): select/channel-index width.
- DWELL, default 16: cycles spent on each channel in scan mode, ≥1.

Ports:
- CLK  in  1  system clock. One clock; all logic on the rising edge.
- RST  in  1  reset. Synchronous, active-high.
- DIN  in  N*W  packed channel data. Channel k occupies DIN[k*W+W-1 : k*W].
- MODE  in  1  0 = manual, 1 = scan.
- SEL  in  SELW  channel request in manual mode.
- EN  in  1  1 = run, 0 = freeze all state and outputs.
- Y  out  W  registered selected data.
- CH  out  SELW  channel index currently driving Y.
- CHG  out  1  one-cycle pulse in the cycle after CH changes value.
- ERR  out  1  registered; high while manual SEL ≥ N.

## Operation
- Two-state FSM. MANUAL (reset state) and SCAN.
  - MODE=1 while in MANUAL → SCAN.
  - MODE=0 while in SCAN → MANUAL.
  - Transitions occur only when EN=1.
- Next-channel logic (CH_n):
  - MANUAL, SEL<N: CH_n = SEL.
  - MANUAL, SEL≥N: CH_n = CH (hold) and ERR_n = 1.
  - SCAN: CH_n = CH until the dwell count reaches DWELL-1. At that point CH_n = (CH==N-1) ? 0 : CH+1.
- Dwell counter DCNT has width $clog2(DWELL+1).
  - In SCAN it increments and wraps to 0 at DWELL-1.
  - It is forced to 0 in MANUAL and on every MANUAL→SCAN entry.
  - Scan resumes from the current CH, not from 0.
- Each EN=1 cycle:
  - CH ← CH_n.
  - Y ← DIN slice CH_n. Y always corresponds to the CH shown in the same cycle.
  - CHG ← (CH_n ≠ CH).
- EN=0: CH, Y, DCNT, FSM state and ERR hold; CHG ← 0.
- ERR ← 0 whenever in SCAN, or in MANUAL with SEL<N.
- Reset values: Y=0, CH=0, CHG=0, ERR=0, DCNT=0, state MANUAL.

## Timing
- Latency: a change on SEL or DIN appears on Y/CH exactly 1 cycle later (EN=1).
- Scan period: with MODE held at 1, CH advances every DWELL cycles. A full sweep takes N*DWELL cycles.
- DWELL=1: CH advances every cycle.
- Wrap: CH=N-1 → 0 at the dwell boundary. Index N is never produced, including when N is not a power of two.
- Simultaneous MODE 1→0 and dwell boundary: manual wins; CH_n = SEL.
- RST asserted mid-scan: all state returns to reset values on that edge. RST overrides EN.
- Y keeps tracking DIN of the held channel every cycle (EN=1), even when CH does not change.

## Structure
- Shared package muxn_pkg:
  - State enum {ST_MANUAL, ST_SCAN}.
  - Mode constants MODE_MANUAL=1'b0 and MODE_SCAN=1'b1.
- One natural sub-module, muxn_dwell_cnt: the dwell counter with clear/enable inputs and a terminal-count output.
- The FSM, channel register and output register stay in the top module.
- The data slice select is combinational indexing of DIN by CH_n.

## Test plan
- Reset: RST=1 for 2 cycles with arbitrary DIN → Y=0, CH=0, CHG=0, ERR=0. After release in MANUAL with SEL=0, Y equals channel 0 one cycle later.
- Manual select: W=8, N=4, DIN={8'hDD,8'hCC,8'hBB,8'hAA}, SEL 0→2 → next cycle Y=8'hCC, CH=2, CHG=1 for one cycle.
- Scan wrap: N=3, DWELL=4, MODE=1 → CH sequence 0,1,2,0 with changes at cycles 4, 8 and 12 after entry. CH never equals 3. CHG pulses at each change.
- Out-of-range: N=3, manual, CH=1, SEL=3 → CH stays 1, ERR=1 next cycle. SEL=0 → CH=0, ERR=0.
- Freeze: EN=0 mid-scan for 10 cycles → CH, Y and DCNT unchanged, CHG=0. After EN=1 the remaining dwell completes before the next advance.
- Simultaneous events: MODE 1→0 at the dwell boundary with SEL=0 and CH=1 → CH=0, no advance to 2. RST during scan → CH=0 on the next cycle.
